mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, meaning word-address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width.
REQ-003 SHALL have parameter MAX_WAIT, default 4, meaning the consecutive fetch-stall cycles before fetch is forced to win.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports if_req in 1, if_addr in AW, if_gnt out 1, if_rvalid out 1, if_rdata out DW: the instruction-fetch requester (read-only).
REQ-007 SHALL have ports d_req in 1, d_we in 1, d_be in 4, d_addr in AW, d_wdata in DW, d_gnt out 1, d_rvalid out 1, d_rdata out DW: the load/store requester.
REQ-008 SHALL have ports mem_en out 1, mem_we out 4, mem_addr out AW, mem_wdata out DW, mem_rdata in DW: a single-port RAM with 1-cycle read latency.

Function
REQ-009 SHALL grant at most one requester per cycle; the grant is combinational, in the same cycle as the request; mem_en=1 in exactly the cycles where if_gnt or d_gnt is 1.
REQ-010 SHALL hold a 2-state priority FSM with states PRIO_D (reset) and PRIO_IF.
REQ-011 In PRIO_D, with both requests high, SHALL grant data; in PRIO_IF SHALL grant fetch.
REQ-012 SHALL keep a fetch wait counter of width clog2(MAX_WAIT+1).
  - Counter increments when if_req=1 and if_gnt=0, saturating at MAX_WAIT.
  - Counter clears when if_gnt=1 or if_req=0.
REQ-013 SHALL move PRIO_D->PRIO_IF when the counter equals MAX_WAIT at the clock edge and if_req=1.
REQ-014 SHALL move PRIO_IF->PRIO_D after any fetch grant, or when if_req=0.
REQ-015 A lone request SHALL be granted in either state.
REQ-016 On a data grant, SHALL drive mem_addr=d_addr and mem_wdata=d_wdata, and mem_we=d_be if d_we=1, otherwise 4'b0000.
REQ-017 On a fetch grant, SHALL drive mem_addr=if_addr and mem_we=0.
REQ-018 With no grant, SHALL drive mem_we=0; mem_addr and mem_wdata are don't-care.
REQ-019 SHALL register a response tag {valid, owner} for each granted read.
REQ-020 Exactly one cycle after a granted read, SHALL assert the owner's rvalid for one cycle and route mem_rdata to that owner's rdata; the other rvalid stays 0.
REQ-021 Writes SHALL produce no rvalid; d_gnt is the write acknowledge.
REQ-022 Requesters hold req, addr, we, be and wdata stable until gnt; the arbiter SHALL NOT latch requests that are dropped before grant.
REQ-023 Back-to-back grants SHALL be supported every cycle; throughput is one access per cycle.
REQ-024 if_rdata and d_rdata SHALL equal mem_rdata when their rvalid=1, and 0 otherwise.

Reset
REQ-025 While rst=1 at a clock edge, SHALL set: FSM=PRIO_D, wait counter=0, response tag invalid.
REQ-026 While rst=1, if_gnt, d_gnt, mem_en and mem_we SHALL be forced to 0 combinationally, so that no access is issued.
REQ-027 A read granted in the cycle before reset asserts SHALL NOT produce rvalid in the reset cycle.
REQ-028 After rst falls, SHALL accept requests in the first cycle.

Structure
REQ-029 SHALL place owner encodings (OWN_IF=0, OWN_D=1), FSM state encodings and the byte-enable width constant in shared package riscv_pkg.
REQ-030 SHALL implement the tag/rdata routing as sub-module mem_resp_route; all remaining logic stays in mem_arbiter.

Verification
REQ-031 Lone fetch: if_req=1, if_addr=8'h10, RAM[0x10]=32'h00500093 -> if_gnt=1 same cycle; next cycle if_rvalid=1, if_rdata=32'h00500093, d_rvalid=0.
REQ-032 Contention: both requests high continuously (d_we=0), MAX_WAIT=4 -> d_gnt for 4 cycles, then if_gnt on the 5th, then d_gnt resumes.
REQ-033 Store: d_we=1, d_be=4'b0011, d_addr=8'h20, d_wdata=32'hAABBCCDD over old RAM 32'h11223344 -> mem_we=4'b0011, no rvalid; a later read of 0x20 returns 32'h1122CCDD.
REQ-034 Back-to-back: fetch reads of 0x00, 0x01 and 0x02 on consecutive cycles -> three consecutive if_rvalid pulses, in address order.
REQ-035 Reset mid-operation: fetch read granted at cycle N, rst=1 at cycle N+1 -> if_rvalid=0 at N+1; FSM=PRIO_D and counter=0 after reset.
REQ-036 Drop before grant: if_req high for 2 stalled cycles, then low -> counter returns to 0, no if_gnt and no if_rvalid is issued.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the memory arbiter: requester owners, priority
// states, the response tag layout and the byte-enable width.
package riscv_pkg;

    localparam int BE_W = 4;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    typedef enum logic {
        PRIO_D  = 1'b0,
        PRIO_IF = 1'b1
    } prio_state_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } resp_tag_t;

endpackage

// File: rtl/mem_resp_route.sv
// Tracks which requester owns the read issued last cycle and steers the
// RAM read data and a one-cycle rvalid pulse back to that requester.
module mem_resp_route
    import riscv_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_rd_grant,
    input  owner_e        i_rd_owner,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_if_rvalid,
    output logic [DW-1:0] o_if_rdata,
    output logic          o_d_rvalid,
    output logic [DW-1:0] o_d_rdata
);

    resp_tag_t r_tag;
    logic      w_live;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag <= '{valid: 1'b0, owner: OWN_IF};
        end else begin
            r_tag <= '{valid: i_rd_grant, owner: i_rd_owner};
        end
    end

    // A read issued just before reset must not surface during the reset cycle.
    assign w_live      = r_tag.valid && !rst;
    assign o_if_rvalid = w_live && (r_tag.owner == OWN_IF);
    assign o_d_rvalid  = w_live && (r_tag.owner == OWN_D);
    assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
    assign o_d_rdata   = o_d_rvalid  ? i_mem_rdata : '0;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch, load/store) for a single-port
// RAM with 1-cycle read latency; data has priority unless fetch starves.
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter  int AW       = 8,
    parameter  int DW       = 32,
    parameter  int MAX_WAIT = 4,
    localparam int WCW      = $clog2(MAX_WAIT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [BE_W-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_en,
    output logic [BE_W-1:0] mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    output prio_state_e     o_dbg_state,
    output logic [WCW-1:0]  o_dbg_wait_cnt
);

    localparam logic [WCW-1:0] MAX_CNT = WCW'(MAX_WAIT);

    prio_state_e    r_state;
    logic [WCW-1:0] r_wait_cnt;
    logic [WCW-1:0] w_cnt_next;
    logic           w_if_gnt;
    logic           w_d_gnt;

    // Data wins a tie unless fetch has been promoted; reset blocks all grants.
    always_comb begin
        w_if_gnt = 1'b0;
        w_d_gnt  = 1'b0;
        if (!rst) begin
            if (d_req && (!if_req || r_state == PRIO_D)) begin
                w_d_gnt = 1'b1;
            end else if (if_req) begin
                w_if_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        w_cnt_next = '0;
        if (if_req && !w_if_gnt) begin
            w_cnt_next = (r_wait_cnt == MAX_CNT) ? r_wait_cnt : r_wait_cnt + 1'b1;
        end
    end

    // Promotion happens on the edge where the stall count reaches MAX_WAIT,
    // so the starved fetch wins in the very next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= PRIO_D;
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= w_cnt_next;
            case (r_state)
                PRIO_D:  if (if_req && w_cnt_next == MAX_CNT) r_state <= PRIO_IF;
                PRIO_IF: if (w_if_gnt || !if_req) r_state <= PRIO_D;
                default: r_state <= PRIO_D;
            endcase
        end
    end

    assign if_gnt    = w_if_gnt;
    assign d_gnt     = w_d_gnt;
    assign mem_en    = w_if_gnt || w_d_gnt;
    assign mem_we    = (w_d_gnt && d_we) ? d_be : '0;
    assign mem_addr  = w_d_gnt ? d_addr : if_addr;
    assign mem_wdata = d_wdata;

    assign o_dbg_state    = r_state;
    assign o_dbg_wait_cnt = r_wait_cnt;

    mem_resp_route #(
        .DW (DW)
    ) u_resp_route (
        .clk         (clk),
        .rst         (rst),
        .i_rd_grant  (w_if_gnt || (w_d_gnt && !d_we)),
        .i_rd_owner  (w_d_gnt ? OWN_D : OWN_IF),
        .i_mem_rdata (mem_rdata),
        .o_if_rvalid (if_rvalid),
        .o_if_rdata  (if_rdata),
        .o_d_rvalid  (d_rvalid),
        .o_d_rdata   (d_rdata)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter with a behavioural RAM,
// a reference arbitration/memory model and a read-response scoreboard.
module tb_mem_arbiter;
    import riscv_pkg::*;

    localparam int AW       = 8;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 4;
    localparam int WCW      = $clog2(MAX_WAIT + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            if_req = 1'b0;
    logic [AW-1:0]   if_addr = '0;
    logic            if_gnt, if_rvalid;
    logic [DW-1:0]   if_rdata;
    logic            d_req = 1'b0, d_we = 1'b0;
    logic [3:0]      d_be = '0;
    logic [AW-1:0]   d_addr = '0;
    logic [DW-1:0]   d_wdata = '0;
    logic            d_gnt, d_rvalid;
    logic [DW-1:0]   d_rdata;
    logic            mem_en;
    logic [3:0]      mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata = '0;
    prio_state_e     o_dbg_state;
    logic [WCW-1:0]  o_dbg_wait_cnt;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .o_dbg_state(o_dbg_state), .o_dbg_wait_cnt(o_dbg_wait_cnt)
    );

    // ---------------- behavioural RAM ----------------
    logic [DW-1:0] ram [0:255];

    always @(posedge clk) begin : ram_port
        logic [DW-1:0] t;
        if (mem_en) begin
            if (mem_we != 4'b0000) begin
                t = ram[mem_addr];
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) t[8*b +: 8] = mem_wdata[8*b +: 8];
                ram[mem_addr] <= t;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    // ---------------- reference model state ----------------
    logic [DW-1:0] ref_mem [0:255];
    int            stall = 0;      // consecutive cycles fetch requested without a grant
    logic [DW-1:0] exp_if_q[$];
    logic [DW-1:0] exp_d_q[$];
    logic [DW-1:0] if_log[$];
    logic [DW-1:0] last_d_rdata = '0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1; drives one cycle, checks grants mid-cycle against
    // the model, records expected read data, returns at next posedge+1.
    task automatic cycle(input logic ifr, input logic [AW-1:0] ia, input logic dr,
                         input logic dwe, input logic [3:0] dbe, input logic [AW-1:0] da,
                         input logic [DW-1:0] dwd, output logic got_ig);
        logic eig, edg;
        logic [DW-1:0] t;
        if_req = ifr; if_addr = ia;
        d_req = dr; d_we = dwe; d_be = dbe; d_addr = da; d_wdata = dwd;
        @(negedge clk);
        eig = 1'b0;
        edg = 1'b0;
        if (!rst) begin
            if (ifr && dr) begin
                if (stall >= MAX_WAIT) eig = 1'b1;
                else edg = 1'b1;
            end else begin
                eig = ifr;
                edg = dr;
            end
        end
        check("if_gnt", if_gnt, eig);
        check("d_gnt", d_gnt, edg);
        check("mem_en", mem_en, eig | edg);
        check("mem_we", mem_we, (edg && dwe) ? dbe : 4'b0000);
        if (eig) check("mem_addr_if", mem_addr, ia);
        if (edg) check("mem_addr_d", mem_addr, da);
        if (edg && dwe) check("mem_wdata", mem_wdata, dwd);
        if (!rst) begin
            check("wait_cnt", o_dbg_wait_cnt, stall);
            check("prio_state", o_dbg_state, (stall >= MAX_WAIT) ? PRIO_IF : PRIO_D);
        end
        got_ig = if_gnt;
        if (eig) exp_if_q.push_back(ref_mem[ia]);
        if (edg) begin
            if (dwe) begin
                t = ref_mem[da];
                for (int b = 0; b < 4; b++)
                    if (dbe[b]) t[8*b +: 8] = dwd[8*b +: 8];
                ref_mem[da] = t;
            end else begin
                exp_d_q.push_back(ref_mem[da]);
            end
        end
        if (rst) stall = 0;
        else if (ifr && !eig) stall = (stall >= MAX_WAIT) ? MAX_WAIT : stall + 1;
        else stall = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        logic g;
        cycle(1'b0, '0, 1'b0, 1'b0, 4'b0000, '0, '0, g);
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        exp_if_q.delete();
        exp_d_q.delete();
        stall = 0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (if_rvalid) begin
                if_log.push_back(if_rdata);
                if (exp_if_q.size() == 0) check("if_rvalid_unexpected", 1, 0);
                else check("if_rdata", if_rdata, exp_if_q.pop_front());
            end else begin
                check("if_rdata_idle", if_rdata, 0);
                if (exp_if_q.size() != 0) begin
                    check("if_rvalid_missing", 0, 1);
                    exp_if_q.delete();
                end
            end
            if (d_rvalid) begin
                last_d_rdata = d_rdata;
                if (exp_d_q.size() == 0) check("d_rvalid_unexpected", 1, 0);
                else check("d_rdata", d_rdata, exp_d_q.pop_front());
            end else begin
                check("d_rdata_idle", d_rdata, 0);
                if (exp_d_q.size() != 0) begin
                    check("d_rvalid_missing", 0, 1);
                    exp_d_q.delete();
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic g;
        for (int i = 0; i < 256; i++) ram[i] = $urandom;
        ram[8'h00] = 32'h00000013;
        ram[8'h01] = 32'h00100113;
        ram[8'h02] = 32'h00200193;
        ram[8'h10] = 32'h00500093;
        ram[8'h20] = 32'h11223344;
        for (int i = 0; i < 256; i++) ref_mem[i] = ram[i];

        @(posedge clk);
        #1;
        assert_reset();
        cycle(1'b1, 8'h10, 1'b1, 1'b0, 4'b0000, 8'h20, '0, g);
        cycle(1'b1, 8'h10, 1'b1, 1'b1, 4'b1111, 8'h20, 32'hDEADBEEF, g);
        rst = 1'b0;
        check("reset_state", o_dbg_state, PRIO_D);
        check("reset_wait_cnt", o_dbg_wait_cnt, 0);

        // lone fetch right after reset
        if_log.delete();
        cycle(1'b1, 8'h10, 1'b0, 1'b0, 4'b0000, '0, '0, g);
        check("lone_fetch_gnt", g, 1);
        idle();
        check("lone_fetch_rsp_count", if_log.size(), 1);
        if (if_log.size() == 1) check("lone_fetch_rdata", if_log[0], 32'h00500093);

        // contention: data four times, then fetch, repeating
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'h05, 1'b1, 1'b0, 4'b0000, AW'(i + 3), '0, g);
            check("contention_if_gnt", g, (i == 4 || i == 9));
        end
        idle();

        // partial store then read back
        cycle(1'b0, '0, 1'b1, 1'b1, 4'b0011, 8'h20, 32'hAABBCCDD, g);
        cycle(1'b0, '0, 1'b1, 1'b0, 4'b0000, 8'h20, '0, g);
        idle();
        check("store_readback", last_d_rdata, 32'h1122CCDD);

        // back-to-back fetches
        if_log.delete();
        for (int i = 0; i < 3; i++) cycle(1'b1, AW'(i), 1'b0, 1'b0, 4'b0000, '0, '0, g);
        idle();
        check("b2b_rsp_count", if_log.size(), 3);
        if (if_log.size() == 3) begin
            check("b2b_rdata0", if_log[0], 32'h00000013);
            check("b2b_rdata1", if_log[1], 32'h00100113);
            check("b2b_rdata2", if_log[2], 32'h00200193);
        end

        // reset right after a granted fetch
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h40, 1'b1, 1'b0, 4'b0000, 8'h41, '0, g);
        if_log.delete();
        cycle(1'b1, 8'h10, 1'b0, 1'b0, 4'b0000, '0, '0, g);
        assert_reset();
        cycle(1'b1, 8'h11, 1'b1, 1'b0, 4'b0000, 8'h12, '0, g);
        rst = 1'b0;
        check("rst_mid_no_rvalid", if_log.size(), 0);
        check("rst_mid_state", o_dbg_state, PRIO_D);
        check("rst_mid_wait_cnt", o_dbg_wait_cnt, 0);

        // fetch dropped before it is granted
        if_log.delete();
        cycle(1'b1, 8'h30, 1'b1, 1'b0, 4'b0000, 8'h31, '0, g);
        check("drop_no_gnt0", g, 0);
        cycle(1'b1, 8'h30, 1'b1, 1'b0, 4'b0000, 8'h32, '0, g);
        check("drop_no_gnt1", g, 0);
        check("drop_wait_before", o_dbg_wait_cnt, 2);
        cycle(1'b0, 8'h30, 1'b1, 1'b0, 4'b0000, 8'h33, '0, g);
        check("drop_wait_cleared", o_dbg_wait_cnt, 0);
        idle();
        check("drop_no_rvalid", if_log.size(), 0);

        // randomized traffic over a small address window
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 99) < 70, AW'($urandom_range(0, 15)),
                  $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 30,
                  4'($urandom_range(0, 15)), AW'($urandom_range(0, 15)), $urandom, g);
        end
        idle();
        idle();
        check("final_if_q_empty", exp_if_q.size(), 0);
        check("final_d_q_empty", exp_d_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
